fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/fetch_unit_if.sv | 36 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, flag bit positions, condition
// codes and the branch condition evaluator.
package cpu_pkg;

  localparam logic [31:0] NOP = 32'hC800_0000;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,  // Z
    COND_NE = 4'h1,  // !Z
    COND_CS = 4'h2,  // C
    COND_CC = 4'h3,  // !C
    COND_MI = 4'h4,  // N
    COND_PL = 4'h5,  // !N
    COND_VS = 4'h6,  // V
    COND_VC = 4'h7,  // !V
    COND_HI = 4'h8,  // C & !Z
    COND_LS = 4'h9,  // !C | Z
    COND_GE = 4'hA,  // N == V
    COND_LT = 4'hB,  // N != V
    COND_GT = 4'hC,  // !Z & (N == V)
    COND_LE = 4'hD,  // Z | (N != V)
    COND_AL = 4'hE,  // always
    COND_NV = 4'hF   // never
  } cond_e;

  function automatic logic cond_taken(input cond_e cond, input logic [3:0] flags);
    logic n, z, c, v, taken;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, branch resolution inputs
// and the decode handshake. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int ADDR_W = 30,
  parameter int OFF_W  = 16
);
  logic [ADDR_W-1:0] imem_a;
  logic              imem_en;
  logic [31:0]       imem_v;

  logic              br_valid;
  logic [3:0]        br_cond;
  logic              br_imm_mode;
  logic [OFF_W-1:0]  br_imm;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_reg;
  logic [3:0]        flags;
  logic              br_taken;

  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_a, imem_en, br_taken, inst_valid, inst_data, inst_pc,
    input  imem_v, br_valid, br_cond, br_imm_mode, br_imm, br_pc, br_reg,
           flags, inst_ready
  );

  modport slave (
    input  imem_a, imem_en, br_taken, inst_valid, inst_data, inst_pc,
    output imem_v, br_valid, br_cond, br_imm_mode, br_imm, br_pc, br_reg,
           flags, inst_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state; flush wins over everything
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches into a prefetch queue,
// delivers queued instructions to decode and redirects on taken branches.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 30,
  parameter int                DEPTH    = 4,
  parameter int                OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         clk_en,
  input  logic         halt,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = 32 + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              inflight_q, inflight_d;

  logic [ADDR_W-1:0] imm_ext, target;
  logic              active, redirect, issue;
  logic              q_push, q_pop, q_empty, q_full;
  logic [CW-1:0]     q_count;
  logic [CW:0]       occupancy;
  logic [QW-1:0]     q_head;

  // Nothing may issue or redirect while reset is held, even combinationally
  assign active   = clk_en & nreset;
  assign redirect = active & bus.br_valid & cond_taken(cond_e'(bus.br_cond), bus.flags);

  assign imm_ext = ADDR_W'($signed(bus.br_imm));
  assign target  = bus.br_imm_mode ? (bus.br_pc + imm_ext) : bus.br_reg;

  // In-flight fetch reserves a slot so its response always has room
  assign occupancy = {1'b0, q_count} + (CW+1)'(inflight_q);
  assign issue     = active & ~halt & ~redirect & (occupancy < (CW+1)'(DEPTH));

  assign q_pop  = active & ~redirect & ~q_empty & bus.inst_ready;
  assign q_push = active & ~redirect & inflight_q & (~q_full | q_pop);

  sync_fifo #(
    .WIDTH(QW),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk     (clk),
    .nreset  (nreset),
    .flush_i (redirect),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .din_i   ({bus.imem_v, infl_pc_q}),
    .dout_o  (q_head),
    .empty_o (q_empty),
    .full_o  (q_full),
    .count_o (q_count)
  );

  // Fetch PC and in-flight tracking; a redirect kills the in-flight response
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    inflight_d = inflight_q;
    if (active) begin
      inflight_d = issue;
      if (redirect) begin
        fetch_pc_d = target;
      end else if (issue) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
        infl_pc_d  = fetch_pc_q;
      end
    end
  end

  // Fetch-side state registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.imem_en    = issue;
  assign bus.imem_a     = fetch_pc_q;
  assign bus.br_taken   = redirect;
  assign bus.inst_valid = ~q_empty;
  assign bus.inst_data  = q_empty ? NOP : q_head[QW-1:ADDR_W];
  assign bus.inst_pc    = q_empty ? '0  : q_head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory that returns the word address as
// data, a sequential stream model for delivered instructions, a
// condition-code vector table and hand-written branch/reset sequences.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int ADDR_W = 30;
  localparam int OFF_W  = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic clk_en = 1'b0;
  logic halt = 1'b0;

  fetch_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .OFF_W   (OFF_W),
    .RESET_PC('0)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .clk_en (clk_en),
    .halt   (halt),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: data = word address, one cycle after the request
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_v <= {2'b00, bus.imem_a};
  end

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       taken;
  } cc_vec_t;

  cc_vec_t           vecs [256];
  logic [15:0]       masks [16];
  int                n_vec = 0;
  int                n_err = 0;
  bit                chk_en = 1'b0;
  logic [ADDR_W-1:0] exp_pc = '0;
  logic [ADDR_W-1:0] base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: check the pending decode transfer against the stream model
  task automatic cyc();
    #1;
    if (chk_en && clk_en && nreset && bus.inst_valid && bus.inst_ready && !bus.br_taken) begin
      chk("stream_pc", 64'(bus.inst_pc), 64'(exp_pc));
      chk("stream_data", 64'(bus.inst_data), {34'd0, exp_pc});
      exp_pc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_branch(input string name, input logic mode, input logic [ADDR_W-1:0] pc,
                           input logic [OFF_W-1:0] imm, input logic [ADDR_W-1:0] rtgt,
                           input logic [ADDR_W-1:0] tgt);
    logic [ADDR_W-1:0] t4;
    bus.br_valid    = 1'b1;
    bus.br_cond     = 4'hE;
    bus.br_imm_mode = mode;
    bus.br_pc       = pc;
    bus.br_imm      = imm;
    bus.br_reg      = rtgt;
    #1;
    chk({name, "_taken"}, 64'(bus.br_taken), 64'(1));
    chk({name, "_noissue"}, 64'(bus.imem_en), 64'(0));
    @(posedge clk);
    @(negedge clk);
    bus.br_valid = 1'b0;
    #1;
    chk({name, "_pulse"}, 64'(bus.br_taken), 64'(0));
    chk({name, "_flushed"}, 64'(bus.inst_valid), 64'(0));
    chk({name, "_target"}, 64'(bus.imem_a), 64'(tgt));
    exp_pc = tgt;
    run(6);
    t4 = tgt + 30'd4;
    chk({name, "_count"}, 64'(exp_pc), 64'(t4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Taken mask per condition, bit index = flags {N,Z,C,V}
    masks = '{16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333, 16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
              16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA, 16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000};
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        vecs[c*16+f] = '{4'(c), 4'(f), masks[c][f]};

    clk_en          = 1'b1;
    halt            = 1'b0;
    bus.inst_ready  = 1'b1;
    bus.br_valid    = 1'b1;
    bus.br_cond     = 4'hE;
    bus.br_imm_mode = 1'b0;
    bus.br_imm      = '0;
    bus.br_pc       = '0;
    bus.br_reg      = '1;
    bus.flags       = 4'h0;

    // Reset holds everything quiet even with a taken branch presented
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_en", 64'(bus.imem_en), 64'(0));
    chk("rst_br_taken", 64'(bus.br_taken), 64'(0));
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
    chk("rst_inst_data", 64'(bus.inst_data), 64'(NOP));
    chk("rst_inst_pc", 64'(bus.inst_pc), 64'(0));
    chk("rst_imem_a", 64'(bus.imem_a), 64'(0));

    // Release: first fetch is presented for the very next edge
    nreset       = 1'b1;
    bus.br_valid = 1'b0;
    #1;
    chk("first_issue_en", 64'(bus.imem_en), 64'(1));
    chk("first_issue_a", 64'(bus.imem_a), 64'(0));
    chk_en = 1'b1;
    run(20);
    chk("stream_count", 64'(exp_pc), 64'(18));

    // Backpressure fills exactly DEPTH entries, then halt drains them
    bus.inst_ready = 1'b0;
    run(10);
    chk("full_imem_en", 64'(bus.imem_en), 64'(0));
    chk("full_valid", 64'(bus.inst_valid), 64'(1));
    chk("full_head_pc", 64'(bus.inst_pc), 64'(exp_pc));
    halt = 1'b1;
    bus.inst_ready = 1'b1;
    base = exp_pc;
    run(8);
    chk("full_drain_count", 64'(exp_pc - base), 64'(DEPTH));
    chk("drained_valid", 64'(bus.inst_valid), 64'(0));
    chk("drained_nop", 64'(bus.inst_data), 64'(NOP));
    halt = 1'b0;
    base = exp_pc;
    run(6);
    chk("restart_count", 64'(exp_pc - base), 64'(4));

    // Halt while streaming: the in-flight word still arrives
    halt = 1'b1;
    base = exp_pc;
    run(5);
    chk("halt_drain_count", 64'(exp_pc - base), 64'(2));
    chk("halt_imem_en", 64'(bus.imem_en), 64'(0));
    halt = 1'b0;
    run(4);

    // Taken branch on a full queue with decode ready
    bus.inst_ready = 1'b0;
    run(6);
    chk("prebr_full", 64'(bus.imem_en), 64'(0));
    bus.inst_ready = 1'b1;
    do_branch("br_full_rel", 1'b1, 30'h10, 16'hFFFC, 30'h0, 30'h0C);

    // Not-taken branches change nothing
    bus.br_valid = 1'b1;
    bus.br_cond  = 4'hF;
    bus.flags    = 4'hF;
    #1;
    chk("nt_never", 64'(bus.br_taken), 64'(0));
    cyc();
    bus.br_cond = 4'h0;
    bus.flags   = 4'h0;
    #1;
    chk("nt_eq", 64'(bus.br_taken), 64'(0));
    cyc();
    bus.br_valid = 1'b0;
    base = exp_pc;
    run(4);
    chk("nt_no_gap", 64'(exp_pc - base), 64'(4));

    // Redirects while streaming with a fetch in flight
    do_branch("br_reg", 1'b0, 30'h0, 16'h0, 30'h100, 30'h100);
    do_branch("br_rel_pos", 1'b1, 30'h20, 16'h0005, 30'h0, 30'h25);
    do_branch("br_reg_max", 1'b0, 30'h0, 16'h0, 30'h3FFFFFFF, 30'h3FFFFFFF);
    do_branch("br_rel_wrap", 1'b1, 30'h0, 16'hFFFF, 30'h0, 30'h3FFFFFFF);

    // clk_en low freezes everything and blocks outputs
    clk_en       = 1'b0;
    bus.br_valid = 1'b1;
    bus.br_cond  = 4'hE;
    #1;
    chk("ce_imem_en", 64'(bus.imem_en), 64'(0));
    chk("ce_br_taken", 64'(bus.br_taken), 64'(0));
    run(4);
    chk("ce_head_pc", 64'(bus.inst_pc), 64'(exp_pc));
    chk("ce_fetch_pc", 64'(bus.imem_a), 64'(exp_pc + 30'd2));
    bus.br_valid = 1'b0;
    clk_en = 1'b1;
    base = exp_pc;
    run(4);
    chk("ce_resume_count", 64'(exp_pc - base), 64'(4));

    // Condition-code table sweep
    chk_en          = 1'b0;
    bus.br_imm_mode = 1'b0;
    bus.br_reg      = 30'h200;
    for (int i = 0; i < 256; i++) begin
      bus.br_valid = 1'b1;
      bus.br_cond  = vecs[i].cond;
      bus.flags    = vecs[i].flags;
      #1;
      chk($sformatf("cond%0h_flags%0h", vecs[i].cond, vecs[i].flags),
          64'(bus.br_taken), 64'(vecs[i].taken));
      @(posedge clk);
      @(negedge clk);
    end
    bus.br_valid = 1'b0;
    run(3);

    // Reset mid-flight discards queue and in-flight word
    nreset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.inst_valid), 64'(0));
    chk("mid_rst_imem_en", 64'(bus.imem_en), 64'(0));
    chk("mid_rst_pc", 64'(bus.imem_a), 64'(0));
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    exp_pc = '0;
    chk_en = 1'b1;
    run(8);
    chk("mid_rst_count", 64'(exp_pc), 64'(6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
